// File: rtl/jt6295_pipe_dec_pkg.sv
// Shared widths, ADPCM tables and channel-state type for the channel pipe decoder.
package jt6295_pipe_dec_pkg;

  localparam int unsigned CH_N    = 4;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned SIG_W   = 12;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned IDX_MAX = 48;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned ATT_W   = 4;
  localparam int unsigned SND_W   = 14;
  localparam int unsigned STEP_W  = 11;
  localparam int unsigned DIFF_W  = 12;
  localparam int unsigned SUM_W   = SIG_W + 2;
  localparam int unsigned DELTA_W = 5;
  localparam int unsigned GAIN_W  = 6;
  localparam int unsigned PROD_W  = SIG_W + GAIN_W + 1;
  localparam int unsigned ST_W    = SIG_W + IDX_W;

  typedef struct packed {
    logic signed [SIG_W-1:0] signal;
    logic [IDX_W-1:0]        index;
  } ch_state_t;

  localparam logic [STEP_W-1:0] STEP [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
    11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
    11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
    11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
    11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
    11'd1552 };

  localparam logic signed [DELTA_W-1:0] DELTA [8] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8 };

  // att 9..15 mute the channel
  localparam logic [GAIN_W-1:0] GAIN [16] = '{
    6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3,
    6'd2,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0 };

endpackage

// File: rtl/jt6295_pipe_dec_if.sv
// Serialized channel pipe plus the mixed sound output of the decoder.
interface jt6295_pipe_dec_if;
  import jt6295_pipe_dec_pkg::*;

  logic                    pipe_en;
  logic [ATT_W-1:0]        pipe_att;
  logic [NIB_W-1:0]        pipe_data;
  logic signed [SND_W-1:0] sound;
  logic                    sample;

  modport master (output pipe_en, pipe_att, pipe_data, input  sound, sample);
  modport slave  (input  pipe_en, pipe_att, pipe_data, output sound, sample);
endinterface

// File: rtl/jt6295_adpcm_step.sv
// One OKI ADPCM decode step: next signal (saturated) and next step index.
module jt6295_adpcm_step
  import jt6295_pipe_dec_pkg::*;
(
  input  logic signed [SIG_W-1:0] signal,
  input  logic [IDX_W-1:0]        index,
  input  logic [NIB_W-1:0]        nibble,
  output logic signed [SIG_W-1:0] signal_nx,
  output logic [IDX_W-1:0]        index_nx
);
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2047);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-2048);

  logic [STEP_W-1:0]       step;
  logic [DIFF_W-1:0]       diff;
  logic signed [SUM_W-1:0] sum;
  logic signed [IDX_W:0]   idx_sum;

  // diff can reach 2910 at the top of the table, so it and the sum carry extra headroom
  always_comb begin
    step = STEP[index];
    diff = DIFF_W'(step >> 3);
    if (nibble[2]) diff = diff + DIFF_W'(step);
    if (nibble[1]) diff = diff + DIFF_W'(step >> 1);
    if (nibble[0]) diff = diff + DIFF_W'(step >> 2);

    if (nibble[3]) sum = SUM_W'(signal) - $signed(SUM_W'(diff));
    else           sum = SUM_W'(signal) + $signed(SUM_W'(diff));

    if (sum > SAT_HI)      signal_nx = SIG_W'(SAT_HI);
    else if (sum < SAT_LO) signal_nx = SIG_W'(SAT_LO);
    else                   signal_nx = SIG_W'(sum);

    idx_sum = $signed({1'b0, index}) + (IDX_W+1)'(DELTA[nibble[2:0]]);
    if (idx_sum[IDX_W])                          index_nx = '0;
    else if (idx_sum > (IDX_W+1)'(IDX_MAX))      index_nx = IDX_W'(IDX_MAX);
    else                                         index_nx = IDX_W'(idx_sum);
  end
endmodule

// File: rtl/jt6295_sh_rst.sv
// Enabled shift register with asynchronous clear; drop is the oldest stage.
module jt6295_sh_rst #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned STAGES = 4
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] drop
);
  logic [WIDTH-1:0] bits [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) bits[i] <= '0;
    end else if (clk_en) begin
      bits[0] <= din;
      for (int i = 1; i < int'(STAGES); i++) bits[i] <= bits[i-1];
    end
  end

  assign drop = bits[STAGES-1];
endmodule

// File: rtl/jt6295_pipe_dec.sv
// Decodes the serialized channel pipe into per-channel ADPCM signals, attenuates
// them and mixes the four channels into one 14-bit sample per frame.
module jt6295_pipe_dec
  import jt6295_pipe_dec_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  jt6295_pipe_dec_if.slave  pipe
);
  localparam logic [SLOT_W-1:0] SLOT_RST = SLOT_W'((CH_N - (LAT % CH_N)) % CH_N);

  logic [SLOT_W-1:0]       slot;
  ch_state_t               head, wr;
  logic signed [SIG_W-1:0] sig_nx;
  logic [IDX_W-1:0]        idx_nx;
  logic [GAIN_W-1:0]       gain;
  logic signed [PROD_W-1:0] prod;
  logic signed [SIG_W-1:0] contrib, contrib_nx;
  logic signed [SND_W-1:0] acc, sound;
  logic                    sample, armed;

  jt6295_adpcm_step u_step (
    .signal    (head.signal),
    .index     (head.index),
    .nibble    (pipe.pipe_data),
    .signal_nx (sig_nx),
    .index_nx  (idx_nx)
  );

  jt6295_sh_rst #(.WIDTH(ST_W), .STAGES(CH_N)) u_ring (
    .rst    (rst),
    .clk    (clk),
    .clk_en (cen),
    .din    (wr),
    .drop   (head)
  );

  // Write-back state and attenuated contribution; a disabled slot restarts from zero
  always_comb begin
    wr         = '0;
    prod       = '0;
    contrib_nx = '0;
    gain       = GAIN[pipe.pipe_att];
    if (pipe.pipe_en) begin
      wr.signal  = sig_nx;
      wr.index   = idx_nx;
      prod       = PROD_W'(sig_nx) * PROD_W'($signed({1'b0, gain}));
      contrib_nx = SIG_W'(prod >>> 5);
    end
  end

  // On slot 0 contrib holds channel 3, closing the frame; the first frame after
  // reset is partial and only clears the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot    <= SLOT_RST;
      contrib <= '0;
      acc     <= '0;
      sound   <= '0;
      sample  <= 1'b0;
      armed   <= 1'b0;
    end else if (!cen) begin
      sample <= 1'b0;
    end else begin
      slot    <= slot + SLOT_W'(1);
      contrib <= contrib_nx;
      if (slot == '0) begin
        sample <= armed;
        if (armed) sound <= acc + SND_W'(contrib);
        acc   <= '0;
        armed <= 1'b1;
      end else begin
        sample <= 1'b0;
        acc    <= acc + SND_W'(contrib);
      end
    end
  end

  assign pipe.sound  = sound;
  assign pipe.sample = sample;
endmodule
